and_gate: RTL and testbench
===========================

Name: and_gate

Overview:
- Bitwise two-input AND primitive with a pure combinational output, a registered copy of the result and a small activity monitor.
- Used as a leaf logic cell in gate-level example designs, and as a known-good DUT for simulation and waveform tooling.
- Activity counters expose how often the AND result is true and how often it rises, for bench self-checking.

Parameters:
WIDTH, 1, bit width of operands a, b and results c, c_q (must be >= 1)
CNT_W, 8, width of activity counters true_cnt and rise_cnt (must be >= 2)

Ports:
clk  input  1  single system clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous and active-low; clears all state
a  input  WIDTH  operand A
b  input  WIDTH  operand B
clr  input  1  synchronous clear of both counters; active-high, one-cycle pulse or level
c  output  WIDTH  combinational result, a & b
c_q  output  WIDTH  registered result, a & b sampled at clk rising edge
true_cnt  output  CNT_W  count of clock edges where (a & b) != 0
rise_cnt  output  CNT_W  count of clock edges where any bit of c_q goes 0->1

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- c = a & b, bitwise and purely combinational.
  - c is independent of clk, rst_n and clr, including during reset.
  - X/Z on inputs propagates per standard AND semantics: 0 dominates, otherwise X.
- Reset (rst_n = 0): c_q, true_cnt and rise_cnt clear to 0 immediately, without waiting for clk. They stay 0 while rst_n is low.
- First rising clk edge after rst_n deasserts performs a normal update.
- Each clk rising edge with rst_n = 1:
  - c_q <= a & b. Latency from a/b to c_q is exactly 1 cycle.
  - hit = ((a & b) != 0), evaluated on pre-edge inputs.
  - rise = ((a & b) & ~c_q) != 0, using the old c_q. It is true when any bit goes from 0 to 1 on this load.
  - If clr = 1: true_cnt <= 0 and rise_cnt <= 0. clr wins over a simultaneous hit or rise; that event is not counted.
  - Else: true_cnt increments by 1 if hit; rise_cnt increments by 1 if rise.
  - Both counters saturate at all-ones (2^CNT_W - 1). They never wrap.
  - A hit or rise at saturation leaves the counter unchanged.
- Priority: rst_n > clr > increment.
- Reset asserted mid-operation: all registered outputs go to 0 at once; c keeps following a & b.
- A holding 1 (c_q already 1, a & b still 1) counts as a hit but not a rise.
- A falling result (1->0) counts as neither.
- No handshake: inputs are sampled every cycle.
- No internal state beyond c_q and the two counters.

Test Plan:
- Truth table, clk running, rst_n=1, WIDTH=1; hold each pair 1 cycle: (a,b) = 00, 01, 10, 11.
  - c = 0, 0, 0, 1 combinationally.
  - c_q follows one cycle later.
  - true_cnt ends at 1; rise_cnt ends at 1.
- Async reset: with a=b=1 for 3 cycles (true_cnt=3, c_q=1), drop rst_n between edges.
  - c_q, true_cnt and rise_cnt read 0 before the next edge.
  - c stays 1 throughout.
- Rise vs hold: sequence a&b = 1, 1, 0, 1 over 4 edges from reset -> true_cnt=3, rise_cnt=2.
- Clear priority: assert clr on the same edge as a&b=1 with c_q=0 -> both counters 0 after that edge; c_q=1.
- Saturation, CNT_W=2: hold a=b=1 for 5 edges -> true_cnt=3 (saturated), rise_cnt=1, no wrap.
- Wide operands, WIDTH=4: a=4'b1100, b=4'b1010 -> c=4'b1000, and c_q=4'b1000 next edge.
  - Then a=4'b0000 -> c=0, and c_q=0 next edge.
  - Then a=4'b1111, b=4'b0001 -> c=4'b0001, c_q=4'b0001 next edge, and that edge increments rise_cnt.

Source files
------------

// File: rtl/and_gate.sv
// and_gate: bitwise AND with a registered copy of the result and
// saturating activity counters (hits and 0->1 rises of the result).

// Saturating up-counter with synchronous clear; holds at all-ones.
module and_gate_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;
  logic             w_max;

  assign w_max = &r_cnt;
  assign o_cnt = r_cnt;

  // clear beats increment; increment is suppressed once saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (i_clr)            r_cnt <= '0;
    else if (i_inc && !w_max)  r_cnt <= r_cnt + 1'b1;
  end
endmodule

module and_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] c_q,
  output logic [CNT_W-1:0] true_cnt,
  output logic [CNT_W-1:0] rise_cnt
);
  logic [WIDTH-1:0] w_and;
  logic             w_hit;
  logic             w_rise;
  logic [WIDTH-1:0] r_cq;

  // pure combinational result, unaffected by clock, reset or clear
  assign w_and  = a & b;
  assign c      = w_and;
  assign c_q    = r_cq;

  // hit: any result bit set; rise: any bit about to load 1 over a stored 0
  assign w_hit  = |w_and;
  assign w_rise = |(w_and & ~r_cq);

  // registered copy of the result, one cycle behind the inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cq <= '0;
    else        r_cq <= w_and;
  end

  and_gate_sat_cnt #(.CNT_W(CNT_W)) u_true_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (clr),
    .i_inc (w_hit),
    .o_cnt (true_cnt)
  );

  and_gate_sat_cnt #(.CNT_W(CNT_W)) u_rise_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (clr),
    .i_inc (w_rise),
    .o_cnt (rise_cnt)
  );
endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: truth table, async reset, rise vs hold,
// clear priority, counter saturation and wide operands.
module tb_and_gate;
  logic clk;
  logic rst_n;

  // base instance: WIDTH=1, CNT_W=8
  logic       a0, b0, clr0;
  logic       c0, cq0;
  logic [7:0] tc0, rc0;

  // saturation instance: WIDTH=1, CNT_W=2
  logic       as, bs, clrs;
  logic       cs, cqs;
  logic [1:0] tcs, rcs;

  // wide instance: WIDTH=4, CNT_W=8
  logic [3:0] aw, bw;
  logic       clrw;
  logic [3:0] cw, cqw;
  logic [7:0] tcw, rcw;

  int total = 0;
  int bad   = 0;

  and_gate #(.WIDTH(1), .CNT_W(8)) u_base (
    .clk(clk), .rst_n(rst_n), .a(a0), .b(b0), .clr(clr0),
    .c(c0), .c_q(cq0), .true_cnt(tc0), .rise_cnt(rc0)
  );

  and_gate #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(as), .b(bs), .clr(clrs),
    .c(cs), .c_q(cqs), .true_cnt(tcs), .rise_cnt(rcs)
  );

  and_gate #(.WIDTH(4), .CNT_W(8)) u_wide (
    .clk(clk), .rst_n(rst_n), .a(aw), .b(bw), .clr(clrw),
    .c(cw), .c_q(cqw), .true_cnt(tcw), .rise_cnt(rcw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge and settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a0 = 0; b0 = 0; clr0 = 0;
    as = 0; bs = 0; clrs = 0;
    aw = '0; bw = '0; clrw = 0;

    // reset state
    #2;
    check("rst_cq",   32'(cq0), 32'd0);
    check("rst_true", 32'(tc0), 32'd0);
    check("rst_rise", 32'(rc0), 32'd0);
    check("rst_sat",  32'(tcs), 32'd0);
    a0 = 1; b0 = 1;
    #1;
    check("rst_c_comb", 32'(c0), 32'd1);
    a0 = 0; b0 = 0;

    @(negedge clk);
    rst_n = 1'b1;

    // truth table
    a0 = 0; b0 = 0; #1;
    check("tt00_c", 32'(c0), 32'd0);
    tick();
    check("tt00_cq", 32'(cq0), 32'd0);
    a0 = 0; b0 = 1; #1;
    check("tt01_c", 32'(c0), 32'd0);
    tick();
    check("tt01_cq", 32'(cq0), 32'd0);
    a0 = 1; b0 = 0; #1;
    check("tt10_c", 32'(c0), 32'd0);
    tick();
    check("tt10_cq", 32'(cq0), 32'd0);
    a0 = 1; b0 = 1; #1;
    check("tt11_c", 32'(c0), 32'd1);
    check("tt11_cq_pre", 32'(cq0), 32'd0);
    tick();
    check("tt11_cq", 32'(cq0), 32'd1);
    check("tt_true", 32'(tc0), 32'd1);
    check("tt_rise", 32'(rc0), 32'd1);

    // hold 1 for two more edges, then async reset between edges
    tick();
    tick();
    check("hold_true", 32'(tc0), 32'd3);
    check("hold_rise", 32'(rc0), 32'd1);
    check("hold_cq",   32'(cq0), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cq",   32'(cq0), 32'd0);
    check("arst_true", 32'(tc0), 32'd0);
    check("arst_rise", 32'(rc0), 32'd0);
    check("arst_c",    32'(c0),  32'd1);
    tick();
    check("arst_hold_cq",   32'(cq0), 32'd0);
    check("arst_hold_true", 32'(tc0), 32'd0);
    check("arst_hold_c",    32'(c0),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // rise vs hold: 1,1,0,1
    a0 = 1; b0 = 1;
    tick();
    tick();
    a0 = 0;
    tick();
    check("fall_cq", 32'(cq0), 32'd0);
    check("fall_rise", 32'(rc0), 32'd1);
    a0 = 1;
    tick();
    check("rvh_true", 32'(tc0), 32'd3);
    check("rvh_rise", 32'(rc0), 32'd2);

    // clear priority over a simultaneous hit and rise
    a0 = 0;
    tick();
    check("pre_clr_cq", 32'(cq0), 32'd0);
    check("pre_clr_true", 32'(tc0), 32'd3);
    a0 = 1; clr0 = 1;
    tick();
    check("clr_true", 32'(tc0), 32'd0);
    check("clr_rise", 32'(rc0), 32'd0);
    check("clr_cq",   32'(cq0), 32'd1);
    clr0 = 0;
    tick();
    check("post_clr_true", 32'(tc0), 32'd1);
    check("post_clr_rise", 32'(rc0), 32'd0);

    // saturation at CNT_W=2
    as = 1; bs = 1;
    repeat (5) tick();
    check("sat_true", 32'(tcs), 32'd3);
    check("sat_rise", 32'(rcs), 32'd1);
    tick();
    check("sat_nowrap", 32'(tcs), 32'd3);

    // wide operands
    aw = 4'b1100; bw = 4'b1010; #1;
    check("w1_c", 32'(cw), 32'h8);
    tick();
    check("w1_cq", 32'(cqw), 32'h8);
    check("w1_rise", 32'(rcw), 32'd1);
    aw = 4'b0000; #1;
    check("w2_c", 32'(cw), 32'h0);
    tick();
    check("w2_cq", 32'(cqw), 32'h0);
    aw = 4'b0x1x; bw = 4'b0011; #1;
    check("wx_c", {28'h0, cw}, {28'h0, 4'b001x});
    aw = 4'b1111; bw = 4'b0001; #1;
    check("w3_c", 32'(cw), 32'h1);
    tick();
    check("w3_cq", 32'(cqw), 32'h1);
    check("w3_rise", 32'(rcw), 32'd2);
    check("w3_true", 32'(tcw), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
